// File: rtl/tcp_header_parser_if.sv
// Stream and metadata bundle between the IPv4 handler, the TCP header parser,
// the payload consumer and the connection controller.
interface tcp_header_parser_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic                  s_axis_tlast;
   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;
   logic                  meta_valid;
   logic                  meta_ready;
   logic [15:0]           meta_src_port;
   logic [15:0]           meta_dst_port;
   logic [31:0]           meta_seq;
   logic [31:0]           meta_ack;
   logic [7:0]            meta_flags;
   logic [15:0]           meta_window;
   logic [5:0]            meta_hdr_len;
   logic [15:0]           meta_payload_len;
   logic                  meta_hdr_err;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, meta_ready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, meta_valid,
             meta_src_port, meta_dst_port, meta_seq, meta_ack, meta_flags,
             meta_window, meta_hdr_len, meta_payload_len, meta_hdr_err
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, meta_ready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, meta_valid,
             meta_src_port, meta_dst_port, meta_seq, meta_ack, meta_flags,
             meta_window, meta_hdr_len, meta_payload_len, meta_hdr_err
   );
endinterface

// File: rtl/tcp_header_parser.sv
// Parses a TCP header from a byte stream, forwards only the payload and
// publishes one metadata record per segment.
module tcp_header_parser #(
   parameter int DATA_WIDTH = 8,
   parameter int MIN_DOFF   = 5
) (
   input  logic clk,
   input  logic rst_n,
   tcp_header_parser_if.slave bus
);
   typedef enum logic [2:0] {S_HDR, S_OPT, S_PAY, S_DROP, S_META} state_t;

   localparam logic [3:0] BASE_DOFF = 4'd5;

   state_t                state_q;
   logic                  run_q;
   logic [5:0]            off_q;
   logic [15:0]           src_q, dst_q, win_q, plen_q;
   logic [31:0]           seq_q, ack_q;
   logic [3:0]            doff_q;
   logic [7:0]            flags_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] mdata_q;
   logic                  mvld_q, mlast_q, meta_vld_q;

   logic       s_rdy, xfer, last;
   logic [7:0] din;
   logic [5:0] hlen;

   assign din  = bus.s_axis_tdata[7:0];
   assign last = bus.s_axis_tlast;
   assign hlen = {doff_q, 2'b00};

   // run_q keeps tready low while in reset so every output reads 0 there.
   always_comb begin
      s_rdy = 1'b0;
      case (state_q)
         S_HDR, S_OPT, S_DROP: s_rdy = run_q;
         S_PAY:                s_rdy = run_q && (!mvld_q || bus.m_axis_tready);
         default:              s_rdy = 1'b0;
      endcase
   end
   assign xfer = s_rdy && bus.s_axis_tvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_HDR;
         run_q      <= 1'b0;
         off_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         seq_q      <= '0;
         ack_q      <= '0;
         doff_q     <= '0;
         flags_q    <= '0;
         win_q      <= '0;
         plen_q     <= '0;
         err_q      <= 1'b0;
         mdata_q    <= '0;
         mvld_q     <= 1'b0;
         mlast_q    <= 1'b0;
         meta_vld_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (mvld_q && bus.m_axis_tready) mvld_q <= 1'b0;
         case (state_q)
            S_HDR: if (xfer) begin
               off_q <= off_q + 6'd1;
               case (off_q)
                  6'd0:  src_q[15:8]   <= din;
                  6'd1:  src_q[7:0]    <= din;
                  6'd2:  dst_q[15:8]   <= din;
                  6'd3:  dst_q[7:0]    <= din;
                  6'd4:  seq_q[31:24]  <= din;
                  6'd5:  seq_q[23:16]  <= din;
                  6'd6:  seq_q[15:8]   <= din;
                  6'd7:  seq_q[7:0]    <= din;
                  6'd8:  ack_q[31:24]  <= din;
                  6'd9:  ack_q[23:16]  <= din;
                  6'd10: ack_q[15:8]   <= din;
                  6'd11: ack_q[7:0]    <= din;
                  6'd12: doff_q        <= din[7:4];
                  6'd13: flags_q       <= din;
                  6'd14: win_q[15:8]   <= din;
                  6'd15: win_q[7:0]    <= din;
                  default: ;
               endcase
               if (off_q == 6'd12 && din[7:4] < 4'(MIN_DOFF)) begin
                  err_q   <= 1'b1;
                  state_q <= last ? S_META : S_DROP;
               end else if (last) begin
                  // A segment ending at byte 19 is only legal without options.
                  if (off_q != 6'd19 || doff_q != BASE_DOFF) err_q <= 1'b1;
                  state_q <= S_META;
               end else if (off_q == 6'd19) begin
                  state_q <= (doff_q == BASE_DOFF) ? S_PAY : S_OPT;
               end
            end
            S_OPT: if (xfer) begin
               off_q <= off_q + 6'd1;
               if (off_q == hlen - 6'd1) begin
                  state_q <= last ? S_META : S_PAY;
               end else if (last) begin
                  err_q   <= 1'b1;
                  state_q <= S_META;
               end
            end
            S_PAY: if (xfer) begin
               mdata_q <= bus.s_axis_tdata;
               mlast_q <= last;
               mvld_q  <= 1'b1;
               if (plen_q != 16'hFFFF) plen_q <= plen_q + 16'd1;
               if (last) state_q <= S_META;
            end
            S_DROP: if (xfer && last) state_q <= S_META;
            S_META: begin
               if (meta_vld_q && bus.meta_ready) begin
                  meta_vld_q <= 1'b0;
                  state_q    <= S_HDR;
                  off_q      <= '0;
                  src_q      <= '0;
                  dst_q      <= '0;
                  seq_q      <= '0;
                  ack_q      <= '0;
                  doff_q     <= '0;
                  flags_q    <= '0;
                  win_q      <= '0;
                  plen_q     <= '0;
                  err_q      <= 1'b0;
               end else if (!mvld_q || bus.m_axis_tready) begin
                  // Drain: record appears only once the last payload beat is gone.
                  meta_vld_q <= 1'b1;
               end
            end
            default: state_q <= S_HDR;
         endcase
      end
   end

   assign bus.s_axis_tready    = s_rdy;
   assign bus.m_axis_tdata     = mdata_q;
   assign bus.m_axis_tvalid    = mvld_q;
   assign bus.m_axis_tlast     = mlast_q;
   assign bus.meta_valid       = meta_vld_q;
   assign bus.meta_src_port    = src_q;
   assign bus.meta_dst_port    = dst_q;
   assign bus.meta_seq         = seq_q;
   assign bus.meta_ack         = ack_q;
   assign bus.meta_flags       = flags_q;
   assign bus.meta_window      = win_q;
   assign bus.meta_hdr_len     = hlen;
   assign bus.meta_payload_len = plen_q;
   assign bus.meta_hdr_err     = err_q;
endmodule
